// File: rtl/zet_wb_arbiter2.sv
// zet_wb_arbiter2: two-master / one-slave Wishbone arbiter for the Zet SoC.
//
// Both masters use the CPU-side bus format: 16-bit data, word address [20:1]
// (carried here as a 20-bit vector whose MSB is the IO/mem tag) and a 2-bit
// byte select. Arbitration happens once per bus cycle: the winner keeps the
// slave for as long as it holds cyc, so locked multi-beat and
// read-modify-write sequences are never split. Ties go round-robin, or
// always to master 0 when PRIORITY_M0 = 1.
//
// Optional feature macro: ZET_ARB_TIMEOUT_EN
//   When defined, a 16-bit counter watches for a strobe that the slave never
//   acknowledges. After TIMEOUT_CYCLES stalled clocks the owning master gets
//   a one-clock err pulse and the slave strobe is masked for that clock. The
//   grant itself is kept until the master drops cyc. When the macro is not
//   defined the err outputs are tied low and no counter exists.
//
// Handshake: a transfer completes in a clock where the granted master's stb
// is high and s_ack_i is high; the ack is forwarded only to the granted
// master, and only while a grant is active (an ack in IDLE is dropped).
module zet_wb_arbiter2 #(
    parameter int PRIORITY_M0    = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic [19:0] m0_adr_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic [19:0] m1_adr_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    input  logic [15:0] s_dat_i,
    output logic [15:0] s_dat_o,
    output logic [19:0] s_adr_o,
    output logic [1:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    // Master that received the most recent grant (0 or 1). Reset to 1 so
    // master 0 wins the first tie.
    logic last_gnt;

    // Strobe of the currently granted master, before any timeout masking.
    logic gnt_stb;

    // High for one clock when the stalled-strobe limit is hit.
    logic timeout;

    // Next-state logic: grant from IDLE, hold while the owner keeps cyc.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (PRIORITY_M0 != 0) begin
                        state_next = GNT0;
                    end else if (last_gnt) begin
                        state_next = GNT0;
                    end else begin
                        state_next = GNT1;
                    end
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and last-grant pointer; reset drops the grant at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == GNT0) begin
                last_gnt <= 1'b0;
            end else if (state == IDLE && state_next == GNT1) begin
                last_gnt <= 1'b1;
            end
        end
    end

    // Raw strobe of whichever master owns the bus.
    always_comb begin
        gnt_stb = 1'b0;
        case (state)
            GNT0:    gnt_stb = m0_stb_i;
            GNT1:    gnt_stb = m1_stb_i;
            default: gnt_stb = 1'b0;
        endcase
    end

`ifdef ZET_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic [15:0] to_limit;

    assign to_limit = 16'(TIMEOUT_CYCLES);
    assign timeout  = (state != IDLE) && (to_cnt == to_limit);

    // Stalled-strobe counter: counts clocks of an unacknowledged strobe and
    // restarts on ack, on a state change, when stb is low, or after firing.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            to_cnt <= 16'd0;
        end else if (state_next != state || timeout || !gnt_stb || s_ack_i) begin
            to_cnt <= 16'd0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Slave-side mux and ack/err steering; everything is zero in IDLE.
    always_comb begin
        s_adr_o  = 20'd0;
        s_dat_o  = 16'd0;
        s_sel_o  = 2'b00;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = gnt_stb && !timeout;
                m0_ack_o = s_ack_i;
                m0_err_o = timeout;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = gnt_stb && !timeout;
                m1_ack_o = s_ack_i;
                m1_err_o = timeout;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign gnt_o = state;

endmodule

// File: tb/tb_zet_wb_arbiter2.sv
// Bench for zet_wb_arbiter2. Two instances share all inputs: one in
// round-robin mode, one with fixed master-0 priority. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_zet_wb_arbiter2;

    logic        clk;
    logic        rst_n;
    logic [15:0] m0_dat, m1_dat, s_dat;
    logic [19:0] m0_adr, m1_adr;
    logic [1:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack;

    logic [15:0] rr_m0_dat, rr_m1_dat, rr_s_dat;
    logic [19:0] rr_s_adr;
    logic [1:0]  rr_s_sel, rr_gnt;
    logic        rr_m0_ack, rr_m0_err, rr_m1_ack, rr_m1_err;
    logic        rr_s_we, rr_s_cyc, rr_s_stb;

    logic [15:0] pr_m0_dat, pr_m1_dat, pr_s_dat;
    logic [19:0] pr_s_adr;
    logic [1:0]  pr_s_sel, pr_gnt;
    logic        pr_m0_ack, pr_m0_err, pr_m1_ack, pr_m1_err;
    logic        pr_s_we, pr_s_cyc, pr_s_stb;

    logic [15:0] rd_exp_q[$];
    logic [38:0] wr_exp_q[$];

    int errors = 0;
    int checks = 0;

    zet_wb_arbiter2 #(.PRIORITY_M0(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_dat_i(m0_dat), .m0_dat_o(rr_m0_dat), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(rr_m0_ack),
        .m0_err_o(rr_m0_err),
        .m1_dat_i(m1_dat), .m1_dat_o(rr_m1_dat), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(rr_m1_ack),
        .m1_err_o(rr_m1_err),
        .s_dat_i(s_dat), .s_dat_o(rr_s_dat), .s_adr_o(rr_s_adr), .s_sel_o(rr_s_sel),
        .s_we_o(rr_s_we), .s_cyc_o(rr_s_cyc), .s_stb_o(rr_s_stb), .s_ack_i(s_ack),
        .gnt_o(rr_gnt)
    );

    zet_wb_arbiter2 #(.PRIORITY_M0(1), .TIMEOUT_CYCLES(8)) dut_pr (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_dat_i(m0_dat), .m0_dat_o(pr_m0_dat), .m0_adr_i(m0_adr), .m0_sel_i(m0_sel),
        .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_ack_o(pr_m0_ack),
        .m0_err_o(pr_m0_err),
        .m1_dat_i(m1_dat), .m1_dat_o(pr_m1_dat), .m1_adr_i(m1_adr), .m1_sel_i(m1_sel),
        .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_ack_o(pr_m1_ack),
        .m1_err_o(pr_m1_err),
        .s_dat_i(s_dat), .s_dat_o(pr_s_dat), .s_adr_o(pr_s_adr), .s_sel_o(pr_s_sel),
        .s_we_o(pr_s_we), .s_cyc_o(pr_s_cyc), .s_stb_o(pr_s_stb), .s_ack_i(s_ack),
        .gnt_o(pr_gnt)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_dat = 16'd0; m0_adr = 20'd0; m0_sel = 2'b00; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_dat = 16'd0; m1_adr = 20'd0; m1_sel = 2'b00; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_dat  = 16'd0; s_ack  = 1'b0;
    endtask

    // Leaves the bench 1 ns after a rising edge, out of reset, both in IDLE.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; s_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (rr_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", rr_gnt); end
        checks++; if (rr_s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", rr_s_cyc); end
        checks++; if (rr_s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b want 0", rr_s_stb); end
        checks++; if (rr_s_we !== 1'b0) begin errors++; $display("FAIL reset_s_we: got %b want 0", rr_s_we); end
        checks++; if ({rr_m0_ack, rr_m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", {rr_m0_ack, rr_m1_ack}); end
        checks++; if ({rr_m0_err, rr_m1_err} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {rr_m0_err, rr_m1_err}); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h0_1234; m0_sel = 2'b11; m0_we = 1'b0;
        rd_exp_q.push_back(16'hBEEF);
        @(negedge clk);
        checks++; if (rr_s_cyc !== 1'b0 || rr_gnt !== 2'b00) begin errors++; $display("FAIL read_latency: got cyc=%b gnt=%b want 0/00", rr_s_cyc, rr_gnt); end
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b01 || rr_s_cyc !== 1'b1) begin errors++; $display("FAIL read_grant: got gnt=%b cyc=%b want 01/1", rr_gnt, rr_s_cyc); end
        checks++; if (rr_s_adr !== 20'h0_1234 || rr_s_we !== 1'b0) begin errors++; $display("FAIL read_adr: got %h we=%b want 01234/0", rr_s_adr, rr_s_we); end
        checks++; if (rr_m0_ack !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b want 0", rr_m0_ack); end
        step();
        s_ack = 1'b1; s_dat = 16'hBEEF;
        @(negedge clk);
        checks++; if (rr_m0_ack !== 1'b1 || rr_m1_ack !== 1'b0) begin errors++; $display("FAIL read_ack: got m0=%b m1=%b want 1/0", rr_m0_ack, rr_m1_ack); end
        if (rr_m0_ack === 1'b1 && rd_exp_q.size() > 0) begin
            logic [15:0] exp_d;
            exp_d = rd_exp_q.pop_front();
            checks++; if (rr_m0_dat !== exp_d) begin errors++; $display("FAIL read_data: got %h want %h", rr_m0_dat, exp_d); end
        end
        checks++; if (rr_m1_dat !== 16'hBEEF) begin errors++; $display("FAIL read_broadcast: got %h want beef", rr_m1_dat); end
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b01 || rr_s_cyc !== 1'b0 || rr_m0_ack !== 1'b0) begin errors++; $display("FAIL read_drop: got gnt=%b cyc=%b ack=%b want 01/0/0", rr_gnt, rr_s_cyc, rr_m0_ack); end
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b00) begin errors++; $display("FAIL read_idle: got %b want 00", rr_gnt); end
        checks++; if (rd_exp_q.size() != 0) begin errors++; $display("FAIL read_queue: got %0d left want 0", rd_exp_q.size()); end
        rd_exp_q.delete();
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h0_0A00;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 20'h0_0B00;
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b01 || pr_gnt !== 2'b01) begin errors++; $display("FAIL rr_first: got rr=%b pr=%b want 01/01", rr_gnt, pr_gnt); end
        step();
        // Ack arrives in the same clock m0 drops cyc.
        s_ack = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clk);
        checks++; if (rr_m0_ack !== 1'b1 || rr_m1_ack !== 1'b0) begin errors++; $display("FAIL rr_drop_ack: got m0=%b m1=%b want 1/0", rr_m0_ack, rr_m1_ack); end
        step();
        s_ack = 1'b1;
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b00 || rr_s_cyc !== 1'b0) begin errors++; $display("FAIL rr_gap: got gnt=%b cyc=%b want 00/0", rr_gnt, rr_s_cyc); end
        checks++; if (rr_m0_ack !== 1'b0 || rr_m1_ack !== 1'b0) begin errors++; $display("FAIL rr_idle_ack: got m0=%b m1=%b want 0/0", rr_m0_ack, rr_m1_ack); end
        step();
        s_ack = 1'b0;
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b10 || rr_s_adr !== 20'h0_0B00) begin errors++; $display("FAIL rr_second: got gnt=%b adr=%h want 10/00b00", rr_gnt, rr_s_adr); end
        step();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b00) begin errors++; $display("FAIL rr_idle2: got %b want 00", rr_gnt); end
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b01) begin errors++; $display("FAIL rr_alternate: got %b want 01", rr_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_priority();
        do_reset();
        for (int r = 0; r < 3; r++) begin
            logic [1:0] exp_rr;
            exp_rr = (r % 2 == 0) ? 2'b01 : 2'b10;
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
            step();
            @(negedge clk);
            checks++; if (rr_gnt !== exp_rr) begin errors++; $display("FAIL prio_rr_round%0d: got %b want %b", r, rr_gnt, exp_rr); end
            checks++; if (pr_gnt !== 2'b01) begin errors++; $display("FAIL prio_fixed_round%0d: got %b want 01", r, pr_gnt); end
            step();
            m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
            step();
            @(negedge clk);
            checks++; if (pr_gnt !== 2'b00) begin errors++; $display("FAIL prio_idle_round%0d: got %b want 00", r, pr_gnt); end
            step();
        end
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        @(negedge clk);
        checks++; if (pr_gnt !== 2'b10 || rr_gnt !== 2'b10) begin errors++; $display("FAIL prio_m1_alone: got pr=%b rr=%b want 10/10", pr_gnt, rr_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_locked_burst();
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b0; m1_we = 1'b1; m1_adr = 20'h1_0060; m1_sel = 2'b01;
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b10) begin errors++; $display("FAIL burst_grant: got %b want 10", rr_gnt); end
        step();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 20'h0_0FFF;
        for (int b = 0; b < 4; b++) begin
            logic [15:0] d;
            logic [38:0] exp_w;
            d = 16'($urandom_range(0, 65535));
            m1_dat = d; m1_stb = 1'b1; s_ack = 1'b1;
            wr_exp_q.push_back({20'h1_0060, 2'b01, 1'b1, d});
            @(negedge clk);
            exp_w = wr_exp_q.pop_front();
            checks++; if ({rr_s_adr, rr_s_sel, rr_s_we, rr_s_dat} !== exp_w) begin errors++; $display("FAIL burst_beat%0d: got %h want %h", b, {rr_s_adr, rr_s_sel, rr_s_we, rr_s_dat}, exp_w); end
            checks++; if (rr_m0_ack !== 1'b0 || rr_m1_ack !== 1'b1 || rr_s_stb !== 1'b1) begin errors++; $display("FAIL burst_ack%0d: got m0=%b m1=%b stb=%b want 0/1/1", b, rr_m0_ack, rr_m1_ack, rr_s_stb); end
            step();
        end
        s_ack = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b10) begin errors++; $display("FAIL burst_hold: got %b want 10", rr_gnt); end
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b00 || rr_m0_ack !== 1'b0) begin errors++; $display("FAIL burst_gap: got gnt=%b ack=%b want 00/0", rr_gnt, rr_m0_ack); end
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b01 || rr_s_adr !== 20'h0_0FFF) begin errors++; $display("FAIL burst_next: got gnt=%b adr=%h want 01/00fff", rr_gnt, rr_s_adr); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1;
        step();
        @(negedge clk);
        checks++; if (rr_s_stb !== 1'b1 || rr_s_cyc !== 1'b1) begin errors++; $display("FAIL midrst_pre: got cyc=%b stb=%b want 1/1", rr_s_cyc, rr_s_stb); end
        m0_cyc = 1'b1; m0_stb = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rr_s_cyc !== 1'b0 || rr_s_stb !== 1'b0) begin errors++; $display("FAIL midrst_drop: got cyc=%b stb=%b want 0/0", rr_s_cyc, rr_s_stb); end
        checks++; if (rr_gnt !== 2'b00) begin errors++; $display("FAIL midrst_gnt: got %b want 00", rr_gnt); end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++; if (rr_gnt !== 2'b01) begin errors++; $display("FAIL midrst_restart: got %b want 01", rr_gnt); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        int pulses;
        do_reset();
        pulses = 0;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            logic exp_err;
`ifdef ZET_ARB_TIMEOUT_EN
            exp_err = (i == 8);
`else
            exp_err = 1'b0;
`endif
            @(negedge clk);
            if (rr_m0_err === 1'b1) pulses++;
            checks++; if (rr_m0_err !== exp_err) begin errors++; $display("FAIL timeout_err%0d: got %b want %b", i, rr_m0_err, exp_err); end
            checks++; if (rr_s_stb !== !exp_err) begin errors++; $display("FAIL timeout_stb%0d: got %b want %b", i, rr_s_stb, !exp_err); end
            checks++; if (rr_gnt !== 2'b01) begin errors++; $display("FAIL timeout_gnt%0d: got %b want 01", i, rr_gnt); end
            step();
        end
`ifdef ZET_ARB_TIMEOUT_EN
        checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
`else
        checks++; if (pulses != 0) begin errors++; $display("FAIL timeout_pulses: got %0d want 0", pulses); end
`endif
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_priority();
        test_locked_burst();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zet_wb_arbiter2.md
Name: zet_wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter for the Zet SoC. It shares one slave port between two requesters, for example the CPU's slave 0 port (base RAM/IO) and a DMA or VGA fetch master.
- Masters use the CPU-side bus format: 16-bit data, address [20:1] where bit 20 is the IO/mem tag, and 2-bit byte select.
- Arbitration is per bus cycle (cyc-locked), round-robin by default, with an optional fixed-priority mode.

Parameters:
- PRIORITY_M0, 0: 0 = round-robin; 1 = master 0 always wins a simultaneous request.
- TIMEOUT_CYCLES, 1023: stalled-strobe limit, in clocks. Used only with ZET_ARB_TIMEOUT_EN. Legal range 1..65535.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- m0_dat_i  in  16  master 0 write data
- m0_dat_o  out  16  master 0 read data
- m0_adr_i  in  20  master 0 address [20:1], bit 20 = IO tag
- m0_sel_i  in  2  master 0 byte select
- m0_we_i  in  1  master 0 write enable
- m0_cyc_i  in  1  master 0 cycle
- m0_stb_i  in  1  master 0 strobe
- m0_ack_o  out  1  master 0 acknowledge
- m0_err_o  out  1  master 0 timeout error
- m1_*  same set as m0_* for master 1
- s_dat_i  in  16  slave read data
- s_dat_o  out  16  slave write data
- s_adr_o  out  20  slave address [20:1]
- s_sel_o  out  2  slave byte select
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant, for debug and observability

Behaviour:
- Reset (wb_rst_n_i low, asynchronous):
  - State IDLE; gnt_o = 2'b00; last-grant pointer = 1, so master 0 wins the first tie.
  - Timeout counter = 0.
  - s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o all 0.
- States:
  - IDLE: no grant.
  - GNT0: master 0 owns the bus.
  - GNT1: master 1 owns the bus.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0. Only m1_cyc_i high -> GNT1.
  - Both high, PRIORITY_M0=1 -> GNT0.
  - Both high, PRIORITY_M0=0 -> grant the master not granted last.
  - On entering GNTx, the last-grant pointer is updated to x.
- GNTx transitions:
  - Hold while mx_cyc_i is high, regardless of the other master's requests. This supports locked multi-beat and read-modify-write sequences.
  - When mx_cyc_i goes low -> IDLE. One idle clock always separates two grants.
- Latency:
  - The grant is registered: s_cyc_o rises one clock after mx_cyc_i rises from IDLE.
  - The slave path adds no further latency.
- Muxing in GNTx (combinational):
  - s_adr_o, s_dat_o, s_sel_o, s_we_o follow master x.
  - s_cyc_o = mx_cyc_i; s_stb_o = mx_stb_i.
  - mx_ack_o = s_ack_i. The ungranted master's ack is 0.
- Muxing in IDLE: s_cyc_o = s_stb_o = s_we_o = 0; s_adr_o, s_dat_o, s_sel_o = 0.
- Read data: m0_dat_o = m1_dat_o = s_dat_i (broadcast). Masters qualify it with their own ack.
- s_ack_i while IDLE: ignored, never forwarded.
- Master dropping cyc in the same clock as the slave ack: the ack is still forwarded that clock; state -> IDLE next clock.
- Reset asserted mid-cycle: the grant is dropped immediately (asynchronously); slave cyc/stb fall with it.

Optional Feature:
- Macro: ZET_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each clock while in GNTx with s_stb_o=1 and s_ack_i=0. It clears on ack, on any state change, or when stb is low.
  - When the count reaches TIMEOUT_CYCLES: mx_err_o pulses high for 1 clock; s_stb_o is forced low in that clock; the counter clears.
  - The grant is kept until the master drops cyc.
- Not defined: m0_err_o and m1_err_o are tied to 0, no counter is built, and the ports remain present.

Test Plan:
- Reset, then m0 single read at adr 20'h0_1234 with slave ack after 2 clocks -> s_cyc_o high 1 clock after m0_cyc_i; m0_ack_o high 1 clock; m0_dat_o = s_dat_i = 16'hBEEF; gnt_o = 01, then 00.
- m0 and m1 raise cyc in the same clock, PRIORITY_M0=0, fresh reset -> GNT0 first. After m0 drops cyc: 1 idle clock, then GNT1. Repeat the simultaneous request -> GNT0 again (alternation).
- Same stimulus with PRIORITY_M0=1, three back-to-back rounds -> master 0 granted each time; master 1 only when m0_cyc_i is low in IDLE.
- m1 granted holding cyc for 4 strobes (IO write, adr 20'h1_0060, sel 2'b01) while m0 requests -> m0_ack_o stays 0; all 4 beats reach the slave unmodified; GNT0 only after m1 drops cyc.
- Assert wb_rst_n_i low mid-grant with s_stb_o high -> s_cyc_o and s_stb_o go 0 without a clock edge; gnt_o = 00; after release, arbitration restarts with master 0 winning the tie.
- With ZET_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, m0 strobes and the slave never acks -> m0_err_o pulses for 1 clock after 8 stalled clocks, s_stb_o is low in that clock, and the grant holds. Without the macro -> no err pulse and the bus stalls.
